// File: rtl/pc_sequencer.sv
// PC sequencer: picks the next-PC source each cycle, holds a redirect until
// instruction memory accepts it, and raises the trap pulse on interrupt entry.
module pc_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IMEM_READY,
    input  logic       STALL_LU,
    input  logic       EX_BR_TAKEN,
    input  logic       EX_JAL,
    input  logic       EX_JALR,
    input  logic       EX_MRET,
    input  logic       INTR,
    input  logic       MIE,
    output logic       PC_WRITE,
    output logic [2:0] PC_SOURCE,
    output logic       FLUSH_IF,
    output logic       FLUSH_ID,
    output logic       TRAP_TAKEN
);

    localparam logic [2:0] SRC_PC4    = 3'd0;
    localparam logic [2:0] SRC_JALR   = 3'd1;
    localparam logic [2:0] SRC_BRANCH = 3'd2;
    localparam logic [2:0] SRC_JAL    = 3'd3;
    localparam logic [2:0] SRC_MTVEC  = 3'd4;
    localparam logic [2:0] SRC_MEPC   = 3'd5;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             held_src_q, held_src_d;
    logic [SYNC_STAGES-1:0] intr_sync_q;

    logic       intr_synced;
    logic       irq_req;
    logic       redirect;
    logic [2:0] win_src;

    assign intr_synced = intr_sync_q[SYNC_STAGES-1];
    assign irq_req     = intr_synced & MIE;

    // Redirect arbitration; an interrupt beats MRET so the MRET is squashed.
    always_comb begin
        redirect = 1'b1;
        win_src  = SRC_PC4;
        if (irq_req) begin
            win_src = SRC_MTVEC;
        end else if (EX_MRET) begin
            win_src = SRC_MEPC;
        end else if (EX_JALR) begin
            win_src = SRC_JALR;
        end else if (EX_JAL) begin
            win_src = SRC_JAL;
        end else if (EX_BR_TAKEN) begin
            win_src = SRC_BRANCH;
        end else begin
            redirect = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        held_src_d = held_src_q;
        PC_WRITE   = 1'b0;
        PC_SOURCE  = SRC_PC4;
        FLUSH_IF   = 1'b0;
        FLUSH_ID   = 1'b0;
        TRAP_TAKEN = 1'b0;

        if (!RST) begin
            if (state_q == ST_HOLD) begin
                // Execute-stage requests and interrupts are ignored until commit.
                PC_SOURCE = held_src_q;
                FLUSH_IF  = 1'b1;
                FLUSH_ID  = 1'b1;
                if (IMEM_READY) begin
                    PC_WRITE = 1'b1;
                    state_d  = ST_RUN;
                end
            end else if (redirect) begin
                PC_SOURCE = win_src;
                FLUSH_IF  = 1'b1;
                FLUSH_ID  = 1'b1;
                if (IMEM_READY) begin
                    PC_WRITE = 1'b1;
                end else begin
                    held_src_d = win_src;
                    state_d    = ST_HOLD;
                end
            end else if (STALL_LU) begin
                FLUSH_ID = 1'b1;
            end else begin
                PC_WRITE = IMEM_READY;
            end
            TRAP_TAKEN = PC_WRITE && (PC_SOURCE == SRC_MTVEC);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_RUN;
            held_src_q  <= SRC_PC4;
            intr_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            held_src_q  <= held_src_d;
            intr_sync_q <= {intr_sync_q[SYNC_STAGES-2:0], INTR};
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed stimulus for pc_sequencer, compared every cycle
// against a transaction-level model of redirect arbitration and hold.
module tb_pc_sequencer;

    localparam int SYNC = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       IMEM_READY = 1'b0;
    logic       STALL_LU = 1'b0;
    logic       EX_BR_TAKEN = 1'b0;
    logic       EX_JAL = 1'b0;
    logic       EX_JALR = 1'b0;
    logic       EX_MRET = 1'b0;
    logic       INTR = 1'b0;
    logic       MIE = 1'b0;
    logic       PC_WRITE;
    logic [2:0] PC_SOURCE;
    logic       FLUSH_IF;
    logic       FLUSH_ID;
    logic       TRAP_TAKEN;

    pc_sequencer #(.SYNC_STAGES(SYNC)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IMEM_READY (IMEM_READY),
        .STALL_LU   (STALL_LU),
        .EX_BR_TAKEN(EX_BR_TAKEN),
        .EX_JAL     (EX_JAL),
        .EX_JALR    (EX_JALR),
        .EX_MRET    (EX_MRET),
        .INTR       (INTR),
        .MIE        (MIE),
        .PC_WRITE   (PC_WRITE),
        .PC_SOURCE  (PC_SOURCE),
        .FLUSH_IF   (FLUSH_IF),
        .FLUSH_ID   (FLUSH_ID),
        .TRAP_TAKEN (TRAP_TAKEN)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    // Reference model state: pending redirect, its source, and INTR history.
    bit m_hold = 0;
    int m_held = 0;
    int intr_hist[$];

    int e_pw, e_src, e_fif, e_fid, e_trap;
    bit e_found;
    int e_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc_n, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_hold = 0;
        m_held = 0;
        intr_hist.delete();
        for (int i = 0; i < SYNC; i++) intr_hist.push_back(0);
    endtask

    task automatic model_eval();
        bit reqs[5];
        int codes[5];
        codes = '{4, 5, 1, 3, 2};
        e_pw = 0; e_src = 0; e_fif = 0; e_fid = 0; e_trap = 0;
        e_found = 0; e_code = 0;
        if (RST) begin
            model_reset();
            return;
        end
        reqs = '{(intr_hist[SYNC-1] != 0) && MIE, EX_MRET, EX_JALR, EX_JAL, EX_BR_TAKEN};
        for (int i = 0; i < 5; i++) begin
            if (reqs[i] && !e_found) begin
                e_found = 1;
                e_code  = codes[i];
            end
        end
        if (m_hold) begin
            e_src = m_held; e_fif = 1; e_fid = 1; e_pw = IMEM_READY;
        end else if (e_found) begin
            e_src = e_code; e_fif = 1; e_fid = 1; e_pw = IMEM_READY;
        end else if (STALL_LU) begin
            e_fid = 1;
        end else begin
            e_pw = IMEM_READY;
        end
        e_trap = (e_pw == 1 && e_src == 4) ? 1 : 0;
    endtask

    task automatic model_clock();
        if (RST) return;
        if (m_hold) begin
            if (IMEM_READY) m_hold = 0;
        end else if (e_found && !IMEM_READY) begin
            m_hold = 1;
            m_held = e_code;
        end
        intr_hist.push_front(int'(INTR));
        void'(intr_hist.pop_back());
    endtask

    task automatic cyc(input bit rst, input bit rdy, input bit stall, input bit br,
                       input bit jal, input bit jalr, input bit mret, input bit intr,
                       input bit mie);
        @(negedge CLK);
        RST = rst; IMEM_READY = rdy; STALL_LU = stall; EX_BR_TAKEN = br;
        EX_JAL = jal; EX_JALR = jalr; EX_MRET = mret; INTR = intr; MIE = mie;
        #1;
        model_eval();
        chk("pc_write",   32'(PC_WRITE),   32'(e_pw));
        chk("pc_source",  32'(PC_SOURCE),  32'(e_src));
        chk("flush_if",   32'(FLUSH_IF),   32'(e_fif));
        chk("flush_id",   32'(FLUSH_ID),   32'(e_fid));
        chk("trap_taken", 32'(TRAP_TAKEN), 32'(e_trap));
        @(posedge CLK);
        model_clock();
        cyc_n++;
    endtask

    initial begin
        model_reset();
        //      rst rdy stl br jal jlr mrt int mie
        cyc(1, 1, 1, 0, 1, 0, 0, 1, 1);
        cyc(1, 1, 0, 1, 0, 1, 1, 1, 1);
        chk("reset_pc_source", 32'(PC_SOURCE), 32'd0);
        // Idle fetch stream
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Redirect overrides load-use stall
        cyc(0, 1, 1, 0, 1, 0, 0, 0, 0);
        // JALR waiting three cycles for the memory
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Interrupt beats a simultaneous MRET once synchronised
        cyc(0, 1, 0, 0, 0, 0, 1, 1, 1);
        cyc(0, 1, 0, 0, 0, 0, 1, 1, 1);
        cyc(0, 1, 0, 0, 0, 0, 1, 1, 1);
        chk("irq_trap_pulse", 32'(TRAP_TAKEN), 32'd1);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Masked interrupt
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Reset discards a held branch redirect
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("hold_branch_src", 32'(PC_SOURCE), 32'd2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Interrupt arriving during HOLD is taken after commit
        cyc(0, 0, 0, 0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit intr_v;
            intr_v = (i % 40) < 12;
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 65),
                ($urandom_range(0, 99) < 25),
                ($urandom_range(0, 99) < 12),
                ($urandom_range(0, 99) < 8),
                ($urandom_range(0, 99) < 8),
                ($urandom_range(0, 99) < 6),
                intr_v ^ ($urandom_range(0, 99) < 5),
                ($urandom_range(0, 99) < 50));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock, CLK, and an asynchronous, active-high reset, RST; no other clock or reset exists.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of flops on the INTR synchronizer (legal 2..3).
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST  in  1  asynchronous active-high reset.
REQ-005 IMEM_READY  in  1  instruction memory accepts a new fetch address this cycle.
REQ-006 STALL_LU  in  1  load-use hazard detected in decode.
REQ-007 EX_BR_TAKEN  in  1  conditional branch resolved taken in execute.
REQ-008 EX_JAL  in  1  JAL in execute.
REQ-009 EX_JALR  in  1  JALR in execute.
REQ-010 EX_MRET  in  1  MRET in execute.
REQ-011 INTR  in  1  external interrupt request, asynchronous level.
REQ-012 MIE  in  1  CSR global interrupt enable.
REQ-013 PC_WRITE  out  1  PC register load enable.
REQ-014 PC_SOURCE  out  3  PC mux select: 0 PC+4, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC, 5 MEPC; 6-7 never driven.
REQ-015 FLUSH_IF  out  1  squash IF/ID register.
REQ-016 FLUSH_ID  out  1  squash ID/EX register (insert bubble).
REQ-017 TRAP_TAKEN  out  1  one-cycle pulse; CSR saves MEPC and clears MIE.

Function
REQ-018 Outputs SHALL be combinational from state, held-source register and inputs; no output latency beyond that.
REQ-019 Request priority SHALL be: interrupt (synced INTR & MIE) > EX_MRET > EX_JALR > EX_JAL > EX_BR_TAKEN > STALL_LU > sequential.
REQ-020 States SHALL be RUN and HOLD; HOLD holds a redirect not yet committed.
REQ-021 RUN, redirect requested, IMEM_READY=1: PC_WRITE=1, PC_SOURCE=winner, FLUSH_IF=FLUSH_ID=1, stay RUN.
REQ-022 RUN, redirect requested, IMEM_READY=0: PC_WRITE=0, latch winner into held-source, FLUSH_IF=FLUSH_ID=1, go HOLD.
REQ-023 HOLD: PC_SOURCE=held-source, FLUSH_IF=FLUSH_ID=1 every cycle; EX_* and interrupt inputs ignored; when IMEM_READY=1, PC_WRITE=1 and go RUN.
REQ-024 RUN, no redirect, STALL_LU=1: PC_WRITE=0, PC_SOURCE=0, FLUSH_ID=1, FLUSH_IF=0, regardless of IMEM_READY.
REQ-025 RUN, no redirect, no stall: PC_WRITE=IMEM_READY, PC_SOURCE=0, flushes 0.
REQ-026 Redirect SHALL override STALL_LU in the same cycle.
REQ-027 TRAP_TAKEN SHALL pulse for exactly the cycle in which PC_WRITE=1 with PC_SOURCE=4; never in the latch cycle.
REQ-028 An interrupt sampled while in HOLD SHALL not be lost: it is evaluated in the first RUN cycle after commit if still asserted.
REQ-029 Interrupt and EX_MRET simultaneous: interrupt wins, MRET is squashed by the flush.
REQ-030 INTR SHALL pass through SYNC_STAGES flops before use; MIE used unsynchronized.

Reset
REQ-031 While RST=1: state RUN, held-source 0, synchronizer flops 0, PC_WRITE=0, PC_SOURCE=0, FLUSH_IF=0, FLUSH_ID=0, TRAP_TAKEN=0.
REQ-032 RST asserted in HOLD SHALL discard the held redirect; first post-reset cycle behaves as RUN.
REQ-033 Reset deassertion SHALL take effect on the next CLK edge with no extra wait cycles.

Verification
REQ-034 IMEM_READY=1, no requests, 4 cycles -> PC_WRITE=1, PC_SOURCE=0 every cycle, all flushes 0.
REQ-035 STALL_LU=1 and EX_JAL=1 same cycle, IMEM_READY=1 -> PC_WRITE=1, PC_SOURCE=3, FLUSH_IF=FLUSH_ID=1.
REQ-036 EX_JALR=1 with IMEM_READY=0 for 3 cycles then 1 -> PC_WRITE=0, PC_SOURCE=1, flushes 1 for 3 cycles; 4th cycle PC_WRITE=1, PC_SOURCE=1, then RUN.
REQ-037 INTR=1, MIE=1, EX_MRET=1 after sync (cycle 2), IMEM_READY=1 -> PC_SOURCE=4, PC_WRITE=1, TRAP_TAKEN=1 for one cycle only.
REQ-038 INTR=1, MIE=0 -> TRAP_TAKEN stays 0, PC_SOURCE never 4.
REQ-039 RST pulsed during HOLD with held-source 2 -> outputs all 0 during reset; first cycle after: PC_SOURCE=0, PC_WRITE=IMEM_READY.
